// File: rtl/wb_uart_sim_dev_if.sv
// Wishbone slave bundle for the simulated UART.
// Master drives cyc/stb/we/addr/sel/dat_i; slave returns bsy/ack/dat_o/mapsz.
interface wb_uart_sim_dev_if #(
  parameter int ARCHBITSZ = 32
);
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8);

  logic                   wb_cyc_i;
  logic                   wb_stb_i;
  logic                   wb_we_i;
  logic [ADDRBITSZ-1:0]   wb_addr_i;
  logic [ARCHBITSZ/8-1:0] wb_sel_i;
  logic [ARCHBITSZ-1:0]   wb_dat_i;
  logic                   wb_bsy_o;
  logic                   wb_ack_o;
  logic [ARCHBITSZ-1:0]   wb_dat_o;
  logic [ARCHBITSZ-1:0]   wb_mapsz_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_addr_i, wb_sel_i, wb_dat_i,
    input  wb_bsy_o, wb_ack_o,
    input  wb_dat_o, wb_mapsz_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_addr_i, wb_sel_i, wb_dat_i,
    output wb_bsy_o, wb_ack_o,
    output wb_dat_o, wb_mapsz_o
  );
endinterface

// File: rtl/wb_uart_sim_dev.sv
// Simulation UART: wishbone slave (wb), TX FIFO drained every TXCLKS
// cycles to tx_data_o/tx_valid_o, RX FIFO filled via rx_*, RX irq_o.
module wb_uart_sim_dev #(
  parameter int ARCHBITSZ = 32,
  parameter int BUFSZ     = 2,
  parameter int TXCLKS    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_uart_sim_dev_if.slave wb,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  output logic             irq_o
);
  localparam int PW = $clog2(BUFSZ);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TXCLKS + 1);
  localparam int AW = ARCHBITSZ - $clog2(ARCHBITSZ/8);
  localparam int SW = ARCHBITSZ / 8;
  localparam logic [CW-1:0] FULL = CW'(BUFSZ);
  localparam logic [TW-1:0] TLAST = TW'(TXCLKS - 1);

  logic [7:0] tx_mem_q [BUFSZ];
  logic [7:0] rx_mem_q [BUFSZ];

  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [TW-1:0] tx_tmr_q, tx_tmr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          irqen_q, irqen_d;
  logic          ack_q, ack_d;
  logic [ARCHBITSZ-1:0] dat_q, dat_d;

  logic req, rd, wr;
  logic a_data, a_stat, a_ctrl;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_pop, tx_push, rx_pop, rx_push;

  assign req    = wb.wb_cyc_i & wb.wb_stb_i;
  assign rd     = req & ~wb.wb_we_i;
  assign wr     = req & wb.wb_we_i;
  assign a_data = wb.wb_addr_i[1:0] == 2'd0;
  assign a_stat = wb.wb_addr_i[1:0] == 2'd1;
  assign a_ctrl = wb.wb_addr_i[1:0] == 2'd2;

  assign tx_full  = tx_cnt_q == FULL;
  assign tx_empty = tx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == FULL;
  assign rx_empty = rx_cnt_q == '0;

  // A pop frees a slot in the same cycle, so a push into a full
  // FIFO still lands when it coincides with a pop.
  assign tx_pop  = ~tx_empty & (tx_tmr_q == TLAST);
  assign tx_push = wr & a_data & wb.wb_sel_i[0] & (~tx_full | tx_pop);
  assign rx_pop  = rd & a_data & ~rx_empty;
  assign rx_push = rx_valid_i & (~rx_full | rx_pop);

  always_comb begin
    tx_wp_d    = tx_wp_q + PW'(tx_push);
    tx_rp_d    = tx_rp_q + PW'(tx_pop);
    rx_wp_d    = rx_wp_q + PW'(rx_push);
    rx_rp_d    = rx_rp_q + PW'(rx_pop);
    tx_cnt_d   = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_cnt_d   = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    tx_tmr_d   = tx_tmr_q + TW'(1);
    tx_valid_d = tx_pop;
    tx_data_d  = tx_data_q;
    irqen_d    = irqen_q;
    ack_d      = req;
    dat_d      = '0;
    // Timer only runs while bytes are queued; it restarts per byte.
    if (tx_empty || tx_pop)
      tx_tmr_d = '0;
    if (tx_pop)
      tx_data_d = tx_mem_q[tx_rp_q];
    if (wr && a_ctrl && wb.wb_sel_i[0])
      irqen_d = wb.wb_dat_i[0];
    if (rd) begin
      unique case (1'b1)
        a_data: if (!rx_empty) dat_d[7:0] = rx_mem_q[rx_rp_q];
        a_stat: begin
          dat_d[0]     = ~rx_empty;
          dat_d[1]     = tx_full;
          dat_d[15:8]  = 8'(rx_cnt_q);
          dat_d[23:16] = 8'(tx_cnt_q);
        end
        a_ctrl: dat_d[0] = irqen_q;
        default: dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tx_tmr_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      irqen_q    <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      irqen_q    <= irqen_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  // Storage needs no reset: counts and pointers gate every access.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= wb.wb_dat_i[7:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_data_i;
  end

`ifdef SIMULATION
  always @(posedge clk_i) begin
    if (!rst_i && tx_pop) begin
      $write("%c", tx_mem_q[tx_rp_q]);
    end
  end
`endif

  assign wb.wb_bsy_o   = 1'b0;
  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_dat_o   = dat_q;
  assign wb.wb_mapsz_o = ARCHBITSZ'(16);
  assign tx_data_o     = tx_data_q;
  assign tx_valid_o    = tx_valid_q;
  assign rx_ready_o    = ~rx_full;
  assign irq_o         = irqen_q & ~rx_empty;

  logic unused;
  assign unused = ^{wb.wb_addr_i[AW-1:2],
                    wb.wb_dat_i[ARCHBITSZ-1:8],
                    wb.wb_sel_i[SW-1:1]};
endmodule

// File: tb/tb_wb_uart_sim_dev.sv
// Bench for wb_uart_sim_dev: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the UART.
module tb_wb_uart_sim_dev;
  localparam int AW = 32;
  localparam int BUFSZ = 2;
  localparam int TXCLKS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic tx_valid, rx_ready, irq;

  wb_uart_sim_dev_if #(.ARCHBITSZ(AW)) bus();

  wb_uart_sim_dev #(
    .ARCHBITSZ(AW), .BUFSZ(BUFSZ), .TXCLKS(TXCLKS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wb(bus),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot = 0;
  int n_fail = 0;

  byte unsigned txq[$];
  byte unsigned rxq[$];
  bit irqen = 1'b0;
  int edge_n = 0;
  int next_emit = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    txq.delete();
    rxq.delete();
    irqen = 1'b0;
  endtask

  // One clock edge: predict from model state, advance, compare.
  task automatic step();
    logic acc, we, txp, txpush, rxp, rxpush, was_empty;
    logic [1:0] a;
    logic [31:0] ed, st;
    byte unsigned wd, rb, popped;
    bit wd0;
    a   = bus.wb_addr_i[1:0];
    we  = bus.wb_we_i;
    wd  = bus.wb_dat_i[7:0];
    wd0 = bus.wb_dat_i[0];
    rb  = rx_data;
    acc = bus.wb_cyc_i & bus.wb_stb_i & !rst;
    st  = {8'h0, 8'(txq.size()), 8'(rxq.size()), 6'h0,
           txq.size() == BUFSZ, rxq.size() != 0};
    ed = 0;
    if (acc && !we) begin
      if (a == 0 && rxq.size() > 0) ed = 32'(rxq[0]);
      if (a == 1) ed = st;
      if (a == 2) ed = {31'b0, irqen};
    end
    rxp = acc && !we && a == 0 && rxq.size() > 0;
    txp = !rst && txq.size() > 0 && edge_n == next_emit;
    txpush = acc && we && a == 0 && bus.wb_sel_i[0]
             && (txq.size() < BUFSZ || txp);
    rxpush = !rst && rx_valid && (rxq.size() < BUFSZ || rxp);
    popped = 0;
    @(posedge clk);
    #1;
    if (rst) model_clear();
    else begin
      was_empty = txq.size() == 0;
      if (txp) popped = txq.pop_front();
      if (txpush) txq.push_back(wd);
      if ((txp || was_empty) && txq.size() > 0)
        next_emit = edge_n + TXCLKS;
      if (rxp) void'(rxq.pop_front());
      if (rxpush) rxq.push_back(rb);
      if (acc && we && a == 2 && bus.wb_sel_i[0]) irqen = wd0;
    end
    edge_n++;
    chk("ack", 32'(bus.wb_ack_o), 32'(acc));
    chk("dat", bus.wb_dat_o, ed);
    chk("txv", 32'(tx_valid), 32'(txp));
    if (txp) chk("txd", 32'(tx_data), 32'(popped));
    chk("irq", 32'(irq), 32'(irqen && rxq.size() > 0));
    chk("rdy", 32'(rx_ready), 32'(rxq.size() < BUFSZ));
  endtask

  task automatic op(input bit cyc, input bit stb, input bit we,
                    input logic [1:0] a, input logic [31:0] d,
                    input logic [3:0] s, input bit rv,
                    input logic [7:0] rb);
    bus.wb_cyc_i  = cyc;
    bus.wb_stb_i  = stb;
    bus.wb_we_i   = we;
    bus.wb_addr_i = 30'(a);
    bus.wb_dat_i  = d;
    bus.wb_sel_i  = s;
    rx_valid      = rv;
    rx_data       = rb;
    step();
    bus.wb_cyc_i  = 1'b0;
    bus.wb_stb_i  = 1'b0;
    bus.wb_we_i   = 1'b0;
    bus.wb_addr_i = '0;
    bus.wb_dat_i  = '0;
    bus.wb_sel_i  = '0;
    rx_valid      = 1'b0;
    rx_data       = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    op(1, 1, 1, a, d, 4'hf, 0, 0);
  endtask

  task automatic rd(input logic [1:0] a);
    op(1, 1, 0, a, 0, 4'hf, 0, 0);
  endtask

  task automatic inj(input logic [7:0] b);
    op(0, 0, 0, 0, 0, 0, 1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int guard;
    logic [31:0] r;
    bus.wb_cyc_i  = 1'b0;
    bus.wb_stb_i  = 1'b0;
    bus.wb_we_i   = 1'b0;
    bus.wb_addr_i = '0;
    bus.wb_dat_i  = '0;
    bus.wb_sel_i  = '0;

    // Reset state and constant outputs
    repeat (2) @(posedge clk);
    #1;
    chk("mapsz", bus.wb_mapsz_o, 32'd16);
    chk("bsy", 32'(bus.wb_bsy_o), 0);
    chk("rst_ack", 32'(bus.wb_ack_o), 0);
    chk("rst_txv", 32'(tx_valid), 0);
    chk("rst_irq", 32'(irq), 0);
    rst = 1'b0;
    rd(1);
    chk("stat0", bus.wb_dat_o, 0);

    // "Hi" back-to-back, TX count 2 -> 1 -> 0
    wr(0, 32'h48);
    wr(0, 32'h69);
    rd(1);
    chk("txcnt2", 32'(bus.wb_dat_o[23:16]), 2);
    idle(2);
    rd(1);
    chk("txcnt1", 32'(bus.wb_dat_o[23:16]), 1);
    idle(3);
    rd(1);
    chk("txcnt0", 32'(bus.wb_dat_o[23:16]), 0);

    // Overfill TX: third byte dropped
    wr(0, 32'h31);
    wr(0, 32'h32);
    wr(0, 32'h33);
    rd(1);
    chk("txfull", 32'(bus.wb_dat_o[1]), 1);
    idle(12);

    // RX byte with irq enabled
    inj(8'h41);
    wr(2, 32'h1);
    chk("irq_on", 32'(irq), 1);
    rd(1);
    chk("stat101", bus.wb_dat_o, 32'h101);
    rd(0);
    chk("rx41", bus.wb_dat_o, 32'h41);
    chk("irq_off", 32'(irq), 0);
    rd(0);
    chk("rxempty", bus.wb_dat_o, 0);

    // RX overflow and simultaneous pop/push while full
    inj(8'ha1);
    inj(8'ha2);
    chk("rdy0", 32'(rx_ready), 0);
    inj(8'ha3);
    op(1, 1, 0, 0, 0, 4'hf, 1, 8'ha4);
    chk("pop_a1", bus.wb_dat_o, 32'ha1);
    rd(1);
    chk("rxcnt2", 32'(bus.wb_dat_o[15:8]), 2);
    rd(0);
    chk("pop_a2", bus.wb_dat_o, 32'ha2);
    rd(0);
    chk("pop_a4", bus.wb_dat_o, 32'ha4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      op(r[0] | r[1], r[1], r[2], r[4:3],
         $urandom, r[8:5], r[11:9] < 3, 8'(r[19:12]));
    end
    idle(12);

    // Async reset right after a TX pulse with bytes still queued
    wr(0, 32'h58);
    wr(0, 32'h59);
    guard = 0;
    while (!(txq.size() > 0 && edge_n == next_emit) && guard < 20) begin
      idle(1);
      guard++;
    end
    chk("wait_tx", 32'(guard < 20), 1);
    rd(1);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk("arst_txv", 32'(tx_valid), 0);
    chk("arst_txd", 32'(tx_data), 0);
    chk("arst_ack", 32'(bus.wb_ack_o), 0);
    chk("arst_dat", bus.wb_dat_o, 0);
    idle(2);
    rst = 1'b0;
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
